midi_message_parser: RTL
========================

# midi_message_parser

Consumes the byte stream from the MIDI UART receiver, a one-cycle `isByteAvailable` strobe with `byteValue`, and assembles complete channel-voice messages. It emits registered, one-cycle-pulsed note-on/note-off and control-change events to the voice allocator. It implements MIDI running status, skips unsupported messages by their correct data length, and ignores system real-time bytes anywhere in the stream.

## Interface
- `OMNI`, default 1: 1 = accept all channels; 0 = accept only `CHANNEL`.
- `CHANNEL`, default 4'd0: receive channel (0–15), used when `OMNI` = 0.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `RESET_N`  in  1  reset; one clock, synchronous, active-low.
- `isByteAvailable`  in  1  one-cycle strobe; `byteValue` is valid in that cycle.
- `byteValue`  in  8  received MIDI byte.
- `noteEventValid`  out  1  one-cycle pulse; note fields are valid.
- `noteOn`  out  1  1 = note on; 0 = note off.
- `noteNumber`  out  7  key number.
- `velocity`  out  7  velocity (release velocity for note off).
- `ccEventValid`  out  1  one-cycle pulse; CC fields are valid.
- `ccNumber`  out  7  controller number.
- `ccValue`  out  7  controller value.
- `channel`  out  4  channel of the most recent emitted event (note or CC).

## Operation
- Byte classes:
  - data: bit7 = 0.
  - channel status: 0x80–0xEF.
  - system common: 0xF0–0xF7.
  - real-time: 0xF8–0xFF.
- Registers:
  - `runStatus[7:0]`, valid flag `rsValid`.
  - `data1[6:0]`.
  - `needed` (1 or 2): data-byte count for the current status.
- Data counts:
  - 0x8n, 0x9n, 0xAn, 0xBn, 0xEn → 2.
  - 0xCn, 0xDn → 1.
- States:
  - S_IDLE: no valid running status.
  - S_DATA1: awaiting the first data byte.
  - S_DATA2: awaiting the second data byte.
- Transitions (evaluated only in cycles where `isByteAvailable` = 1):
  - Real-time byte in any state: ignored. State, running status and `data1` are unchanged.
  - Channel status byte in any state:
    - latch `runStatus`, set `rsValid` and `needed`, go to S_DATA1.
    - Any partial message is abandoned silently.
  - System common byte in any state: clear `rsValid`, go to S_IDLE. SysEx payloads and common-message data are then discarded as stray data.
  - Data byte in S_IDLE: discarded.
  - Data byte in S_DATA1:
    - `needed` = 2: store to `data1`, go to S_DATA2.
    - `needed` = 1: message complete (no output for 0xCn/0xDn), stay in S_DATA1.
  - Data byte in S_DATA2: message complete, return to S_DATA1 (running status).
- On message completion, if the message's channel is accepted (`OMNI` = 1, or channel == `CHANNEL`):
  - 0x9n with second byte ≠ 0: note event, `noteOn` = 1.
  - 0x9n with second byte = 0: note event, `noteOn` = 0, `velocity` = 0.
  - 0x8n: note event, `noteOn` = 0, `velocity` = second byte.
  - 0xBn: CC event, `ccNumber` = `data1`, `ccValue` = second byte.
  - 0xAn, 0xEn, 0xCn, 0xDn: parsed, no output.
- On a rejected channel, the message is parsed identically with no output pulse.
- Output fields hold their last value until the next event of the same kind. `channel` updates on either kind of event.

## Timing
- Reset (`RESET_N` = 0 at a `CLOCK_50` edge):
  - state → S_IDLE; `rsValid`, `runStatus`, `data1` → 0.
  - All outputs → 0.
  - Applies even mid-message: the partial message is lost and running status is cleared.
- Latency: an event pulse is asserted in the cycle after the `isByteAvailable` cycle carrying the final data byte. It lasts exactly one cycle.
- `noteEventValid` and `ccEventValid` are never high in the same cycle.
- Strobes may arrive in consecutive cycles; each is processed, with no backpressure and no drops.
- `isByteAvailable` = 0 in a cycle: no state change, and both valid pulses deassert.

## Test plan
- Note on, `OMNI` = 1: 0x93, 0x3C, 0x64 → one `noteEventValid` pulse with `noteOn` = 1, `noteNumber` = 60, `velocity` = 100, `channel` = 3, one cycle after the 0x64 strobe.
- Running status and zero-velocity note on: 0x90, 0x40, 0x7F, 0x40, 0x00 → two pulses: first on (64, 127), second `noteOn` = 0, `velocity` = 0.
- Real-time interleave and CC: 0xB1, 0xF8, 0x07, 0xFE, 0x55 → single `ccEventValid` with `ccNumber` = 7, `ccValue` = 0x55, `channel` = 1; no note pulse.
- SysEx and skipped messages:
  - 0xF0, 0x7E, 0x09, 0xF7, 0x45, 0x45 → no pulses.
  - Then 0xC0, 0x05, 0x06 → no pulses.
  - Then 0x80, 0x30, 0x20 → note off, `noteNumber` = 48, `velocity` = 32.
- Channel filter, `OMNI` = 0, `CHANNEL` = 2: 0x95, 0x3C, 0x64 → no pulse; 0x92, 0x3C, 0x64 → pulse with `channel` = 2.
- Reset mid-message: 0x90, 0x3C, then `RESET_N` low one cycle, then 0x64 → no pulse, all outputs 0. Status 0x90 is then required before any further note event.

Source files
------------

// File: rtl/midi_message_parser.sv
// rtl/midi_message_parser.sv - MIDI byte-stream parser emitting note and control-change events
module midi_message_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       isByteAvailable,
    input  logic [7:0] byteValue,
    output logic       noteEventValid,
    output logic       noteOn,
    output logic [6:0] noteNumber,
    output logic [6:0] velocity,
    output logic       ccEventValid,
    output logic [6:0] ccNumber,
    output logic [6:0] ccValue,
    output logic [3:0] channel
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA1 = 2'd1,
        S_DATA2 = 2'd2
    } state_t;

    state_t     state, stateNext;
    logic [7:0] runStatus, runStatusNext;
    logic       rsValid, rsValidNext;
    logic [6:0] data1, data1Next;
    logic [1:0] needed, neededNext;

    logic       noteFire;
    logic       ccFire;
    logic       noteOnNext;

    logic       isData;
    logic       isChannelStatus;
    logic       isSystemCommon;
    logic       channelAccepted;

    assign isData          = ~byteValue[7];
    assign isChannelStatus = byteValue[7] && (byteValue[7:4] != 4'hF);
    assign isSystemCommon  = (byteValue[7:3] == 5'b11110);
    assign channelAccepted = OMNI || (runStatus[3:0] == CHANNEL);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            runStatus <= 8'h00;
            rsValid   <= 1'b0;
            data1     <= 7'h00;
            needed    <= 2'd0;
        end else begin
            state     <= stateNext;
            runStatus <= runStatusNext;
            rsValid   <= rsValidNext;
            data1     <= data1Next;
            needed    <= neededNext;
        end
    end

    // Real-time bytes (0xF8-0xFF) fall through every branch and leave the parse untouched.
    always_comb begin
        stateNext     = state;
        runStatusNext = runStatus;
        rsValidNext   = rsValid;
        data1Next     = data1;
        neededNext    = needed;
        noteFire      = 1'b0;
        ccFire        = 1'b0;
        noteOnNext    = 1'b0;

        if (isByteAvailable) begin
            if (isData) begin
                case (state)
                    S_DATA1: begin
                        if (needed == 2'd2) begin
                            data1Next = byteValue[6:0];
                            stateNext = S_DATA2;
                        end
                    end
                    S_DATA2: begin
                        stateNext = S_DATA1;
                        if (rsValid && channelAccepted) begin
                            case (runStatus[7:4])
                                4'h9: begin
                                    noteFire   = 1'b1;
                                    noteOnNext = (byteValue[6:0] != 7'd0);
                                end
                                4'h8: begin
                                    noteFire   = 1'b1;
                                    noteOnNext = 1'b0;
                                end
                                4'hB: ccFire = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end else if (isChannelStatus) begin
                runStatusNext = byteValue;
                rsValidNext   = 1'b1;
                neededNext    = (byteValue[7:4] == 4'hC || byteValue[7:4] == 4'hD) ? 2'd1 : 2'd2;
                stateNext     = S_DATA1;
            end else if (isSystemCommon) begin
                rsValidNext = 1'b0;
                stateNext   = S_IDLE;
            end
        end
    end

    // Velocity for 0x9n with zero second byte is naturally zero, so no special case is needed.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            noteEventValid <= 1'b0;
            noteOn         <= 1'b0;
            noteNumber     <= 7'h00;
            velocity       <= 7'h00;
            ccEventValid   <= 1'b0;
            ccNumber       <= 7'h00;
            ccValue        <= 7'h00;
            channel        <= 4'h0;
        end else begin
            noteEventValid <= noteFire;
            ccEventValid   <= ccFire;
            if (noteFire) begin
                noteOn     <= noteOnNext;
                noteNumber <= data1;
                velocity   <= byteValue[6:0];
                channel    <= runStatus[3:0];
            end
            if (ccFire) begin
                ccNumber <= data1;
                ccValue  <= byteValue[6:0];
                channel  <= runStatus[3:0];
            end
        end
    end

endmodule
